// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a registered
// borrow computes A - B over WIDTH clocks, LSB first.

// Single full-subtractor cell: d = a - b - bin, bout = borrow out.
module serial_subtractor_fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             diff_valid,
  output logic             diff_bit,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d, br_nxt;
  logic             last;

  // The cell only ever sees register outputs, so the serial stream has no
  // combinational path from any input port.
  serial_subtractor_fs u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (d),
    .bout (br_nxt)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    diff_valid = 1'b0;
    diff_bit   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy       = 1'b1;
        diff_valid = 1'b1;
        diff_bit   = d;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand shifters, borrow, bit counter and result registers.
  // borrow_out takes the final borrow on the edge into DONE so that it is
  // already valid alongside diff while done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh <= a;
          b_sh <= b;
          br   <= 1'b0;
          cnt  <= '0;
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_nxt;
          cnt  <= cnt + 1'b1;
          diff <= {d, diff[WIDTH-1:1]};
          if (last) borrow_out <= br_nxt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH 2, 8 and 13.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance (directed tests and random)
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, diff_valid, diff_bit, done, borrow_out;
  logic [7:0] diff;

  // WIDTH=2 and WIDTH=13 instances (random only)
  logic        rs = 1'b0;
  logic [1:0]  a2 = '0, b2 = '0, df2;
  logic [12:0] a13 = '0, b13 = '0, df13;
  logic        busy2, dv2, db2, dn2, bo2;
  logic        busy13, dv13, db13, dn13, bo13;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .diff_valid(diff_valid), .diff_bit(diff_bit), .done(done),
    .diff(diff), .borrow_out(borrow_out));

  serial_subtractor #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .start(rs), .a(a2), .b(b2),
    .busy(busy2), .diff_valid(dv2), .diff_bit(db2), .done(dn2),
    .diff(df2), .borrow_out(bo2));

  serial_subtractor #(.WIDTH(13)) u13 (
    .clk(clk), .rst(rst), .start(rs), .a(a13), .b(b13),
    .busy(busy13), .diff_valid(dv13), .diff_bit(db13), .done(dn13),
    .diff(df13), .borrow_out(bo13));

  // index 0 = WIDTH 2, 1 = WIDTH 8, 2 = WIDTH 13
  logic [2:0]  dv_v, db_v, dn_v, bo_v;
  logic [31:0] df_v [3];
  always_comb begin
    dv_v    = {dv13, diff_valid, dv2};
    db_v    = {db13, diff_bit, db2};
    dn_v    = {dn13, done, dn2};
    bo_v    = {bo13, borrow_out, bo2};
    df_v[0] = 32'(df2);
    df_v[1] = 32'(diff);
    df_v[2] = 32'(df13);
  end

  int npass = 0, ntot = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else npass++;
  endtask

  // One WIDTH=8 operation; optionally pokes start with 0xFF/0x00 mid-RUN.
  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] ed, input logic eb, input logic poke);
    logic [7:0] s;
    s = '0;
    @(negedge clk); start = 1'b1; a = av; b = bv;
    @(negedge clk); start = 1'b0; a = 8'hxx; b = 8'hxx;
    for (int k = 0; k < 8; k++) begin
      chk({tag, " valid"}, 32'(diff_valid), 1);
      chk({tag, " busy"}, 32'(busy), 1);
      chk({tag, " no done in run"}, 32'(done), 0);
      s[k] = diff_bit;
      if (poke && k == 3) begin start = 1'b1; a = 8'hFF; b = 8'h00; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " done"}, 32'(done), 1);
    chk({tag, " diff"}, 32'(diff), 32'(ed));
    chk({tag, " borrow"}, 32'(borrow_out), 32'(eb));
    chk({tag, " stream"}, 32'(s), 32'(ed));
    @(negedge clk);
    chk({tag, " idle done"}, 32'(done), 0);
    chk({tag, " idle valid"}, 32'(diff_valid), 0);
    chk({tag, " idle bit"}, 32'(diff_bit), 0);
    chk({tag, " hold diff"}, 32'(diff), 32'(ed));
    chk({tag, " hold borrow"}, 32'(borrow_out), 32'(eb));
  endtask

  task automatic no_done(input string tag, input int cycles);
    int n;
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk(tag, 32'(n), 0);
  endtask

  initial begin
    int          ndn, c1, c2;
    int          wd   [3];
    logic [31:0] mask [3];
    logic [31:0] ra [3], rb [3], ed [3], st [3];
    int          pos [3], nd [3];
    wd = '{2, 8, 13};
    for (int i = 0; i < 3; i++) mask[i] = (32'd1 << wd[i]) - 1;

    // reset state
    #1;
    chk("rst busy", 32'(busy), 0);
    chk("rst valid", 32'(diff_valid), 0);
    chk("rst bit", 32'(diff_bit), 0);
    chk("rst done", 32'(done), 0);
    chk("rst diff", 32'(diff), 0);
    chk("rst borrow", 32'(borrow_out), 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;

    // main case: stream 1,1,1,0,1,1,0,0
    op8("5a-23", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
    op8("10-20", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
    op8("00-01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    op8("80-80", 8'h80, 8'h80, 8'h00, 1'b0, 1'b0);

    // start during RUN is ignored
    op8("ignored", 8'h05, 8'h03, 8'h02, 1'b0, 1'b1);
    no_done("ignored extra done", 12);

    // reset mid-RUN
    @(negedge clk); start = 1'b1; a = 8'h5A; b = 8'h23;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; #1;
    chk("midrst busy", 32'(busy), 0);
    chk("midrst valid", 32'(diff_valid), 0);
    chk("midrst bit", 32'(diff_bit), 0);
    chk("midrst done", 32'(done), 0);
    chk("midrst diff", 32'(diff), 0);
    chk("midrst borrow", 32'(borrow_out), 0);
    @(negedge clk); rst = 1'b0;
    no_done("midrst no done", 12);
    op8("09-04", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

    // back-to-back with start held high
    @(negedge clk); start = 1'b1; a = 8'h5A; b = 8'h23;
    ndn = 0; c1 = 0; c2 = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c == 1) begin a = 8'h10; b = 8'h20; end
      if (c == 10) chk("b2b hold diff", 32'(diff), 32'h37);
      if (done) begin
        ndn++;
        if (ndn == 1) begin
          c1 = c;
          chk("b2b diff1", 32'(diff), 32'h37);
          chk("b2b borrow1", 32'(borrow_out), 0);
        end else if (ndn == 2) begin
          c2 = c;
          chk("b2b diff2", 32'(diff), 32'hF0);
          chk("b2b borrow2", 32'(borrow_out), 1);
        end
      end
      if (c == 11) start = 1'b0;
    end
    chk("b2b done count", 32'(ndn), 2);
    chk("b2b first done", 32'(c1), 9);
    chk("b2b gap", 32'(c2 - c1), 10);

    // random regression on all three widths in parallel
    for (int it = 0; it < 1000; it++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        ra[i]  = $urandom & mask[i];
        rb[i]  = $urandom & mask[i];
        ed[i]  = (ra[i] - rb[i]) & mask[i];
        st[i]  = '0;
        pos[i] = 0;
        nd[i]  = 0;
      end
      a2 = ra[0][1:0];  b2 = rb[0][1:0];
      a  = ra[1][7:0];  b  = rb[1][7:0];
      a13 = ra[2][12:0]; b13 = rb[2][12:0];
      rs = 1'b1; start = 1'b1;
      @(negedge clk); rs = 1'b0; start = 1'b0;
      for (int c = 1; c <= 15; c++) begin
        for (int i = 0; i < 3; i++) begin
          if (dv_v[i]) begin st[i][pos[i]] = db_v[i]; pos[i]++; end
          if (dn_v[i]) begin
            nd[i]++;
            chk($sformatf("rnd w%0d diff", wd[i]), df_v[i], ed[i]);
            chk($sformatf("rnd w%0d borrow", wd[i]), 32'(bo_v[i]), 32'(ra[i] < rb[i]));
          end
        end
        @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rnd w%0d stream", wd[i]), st[i], ed[i]);
        chk($sformatf("rnd w%0d nbits", wd[i]), 32'(pos[i]), 32'(wd[i]));
        chk($sformatf("rnd w%0d ndone", wd[i]), 32'(nd[i]), 1);
      end
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
